// File: rtl/motors_dispatcher.sv
// Servo-then-step command dispatcher for the plotter: moves the pen servo, waits for it
// to settle, then drives concurrent X/Y step/dir pulse trains; also holds current position.
package motors_dispatcher_pkg;
  localparam logic SERVO_POS_UP   = 1'b0;
  localparam logic SERVO_POS_DOWN = 1'b1;
endpackage

module motors_dispatcher
  import motors_dispatcher_pkg::*;
#(
  parameter int PULSE_NUM_WIDTH     = 16,
  parameter int POS_WIDTH           = 16,
  parameter int STEP_PERIOD_CYCLES  = 4,
  parameter int SERVO_SETTLE_CYCLES = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic signed [PULSE_NUM_WIDTH-1:0] pulse_num_x,
  input  logic signed [PULSE_NUM_WIDTH-1:0] pulse_num_y,
  input  logic                        servo_pos,
  input  logic                        trigger,
  input  logic signed [POS_WIDTH-1:0] new_x,
  input  logic signed [POS_WIDTH-1:0] new_y,
  input  logic                        update,
  output logic                        step_x,
  output logic                        dir_x,
  output logic                        step_y,
  output logic                        dir_y,
  output logic                        servo_out,
  output logic                        busy,
  output logic                        done,
  output logic signed [POS_WIDTH-1:0] cur_x,
  output logic signed [POS_WIDTH-1:0] cur_y
);

  localparam int MW = PULSE_NUM_WIDTH + 1;
  localparam int PW = (STEP_PERIOD_CYCLES > 2) ? $clog2(STEP_PERIOD_CYCLES) : 1;
  localparam int SW = (SERVO_SETTLE_CYCLES > 1) ? $clog2(SERVO_SETTLE_CYCLES) : 1;
  localparam logic [PW-1:0] PHASE_LAST  = PW'(STEP_PERIOD_CYCLES - 1);
  localparam logic [PW-1:0] PHASE_HALF  = PW'(STEP_PERIOD_CYCLES / 2);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SERVO_SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SERVO_WAIT,
    STEPPING,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [MW-1:0]   rem_x_q, rem_x_d, rem_y_q, rem_y_d;
  logic [MW-1:0]   rem_x_dec, rem_y_dec;
  logic [PW-1:0]   phase_q, phase_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic            servo_q, servo_d;
  logic signed [POS_WIDTH-1:0] cur_x_q, cur_y_q;

  // One extra bit so the most negative count has a representable magnitude.
  function automatic logic [MW-1:0] magnitude(input logic [PULSE_NUM_WIDTH-1:0] v);
    logic [MW-1:0] ext;
    ext = {v[PULSE_NUM_WIDTH-1], v};
    return v[PULSE_NUM_WIDTH-1] ? (~ext + MW'(1)) : ext;
  endfunction

  assign rem_x_dec = (rem_x_q != '0) ? rem_x_q - MW'(1) : rem_x_q;
  assign rem_y_dec = (rem_y_q != '0) ? rem_y_q - MW'(1) : rem_y_q;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    rem_x_d  = rem_x_q;
    rem_y_d  = rem_y_q;
    phase_d  = phase_q;
    settle_d = settle_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    servo_d  = servo_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          rem_x_d  = magnitude(pulse_num_x);
          rem_y_d  = magnitude(pulse_num_y);
          dir_x_d  = pulse_num_x[PULSE_NUM_WIDTH-1];
          dir_y_d  = pulse_num_y[PULSE_NUM_WIDTH-1];
          servo_d  = servo_pos;
          phase_d  = '0;
          settle_d = '0;
          state_d  = (servo_pos != servo_q) ? SERVO_WAIT : STEPPING;
        end
      end
      SERVO_WAIT: begin
        if (settle_q == SETTLE_LAST) begin
          settle_d = '0;
          state_d  = STEPPING;
        end else begin
          settle_d = settle_q + SW'(1);
        end
      end
      STEPPING: begin
        if (rem_x_q == '0 && rem_y_q == '0) begin
          state_d = DONE;
        end else if (phase_q == PHASE_LAST) begin
          phase_d = '0;
          rem_x_d = rem_x_dec;
          rem_y_d = rem_y_dec;
          if (rem_x_dec == '0 && rem_y_dec == '0) state_d = DONE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rem_x_q  <= '0;
      rem_y_q  <= '0;
      phase_q  <= '0;
      settle_q <= '0;
      dir_x_q  <= 1'b0;
      dir_y_q  <= 1'b0;
      servo_q  <= SERVO_POS_UP;
    end else begin
      state_q  <= state_d;
      rem_x_q  <= rem_x_d;
      rem_y_q  <= rem_y_d;
      phase_q  <= phase_d;
      settle_q <= settle_d;
      dir_x_q  <= dir_x_d;
      dir_y_q  <= dir_y_d;
      servo_q  <= servo_d;
    end
  end

  // Position tracking is independent of the command FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_x_q <= '0;
      cur_y_q <= '0;
    end else if (update) begin
      cur_x_q <= new_x;
      cur_y_q <= new_y;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign step_x    = (state_q == STEPPING) && (phase_q < PHASE_HALF) && (rem_x_q != '0);
  assign step_y    = (state_q == STEPPING) && (phase_q < PHASE_HALF) && (rem_y_q != '0);
  assign dir_x     = dir_x_q;
  assign dir_y     = dir_y_q;
  assign servo_out = servo_q;
  assign cur_x     = cur_x_q;
  assign cur_y     = cur_y_q;

endmodule

// File: tb/tb_motors_dispatcher.sv
// Bench for motors_dispatcher: directed scenarios plus randomized commands checked
// against a command-level model (pulse counts, latency, direction, servo, position).
module tb_motors_dispatcher;
  import motors_dispatcher_pkg::*;

  localparam int W      = 16;
  localparam int PERIOD = 4;
  localparam int SETTLE = 8;
  localparam int F_PERIOD = 2;
  localparam int F_SETTLE = 1;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic signed [W-1:0] pulse_num_x = '0, pulse_num_y = '0, new_x = '0, new_y = '0;
  logic servo_pos = SERVO_POS_UP, trigger = 1'b0, update = 1'b0;
  logic step_x, dir_x, step_y, dir_y, servo_out, busy, done;
  logic signed [W-1:0] cur_x, cur_y;

  logic signed [W-1:0] f_pulse_num_x = '0, f_pulse_num_y = '0, f_new_x = '0, f_new_y = '0;
  logic f_servo_pos = SERVO_POS_UP, f_trigger = 1'b0, f_update = 1'b0;
  logic f_step_x, f_dir_x, f_step_y, f_dir_y, f_servo_out, f_busy, f_done;
  logic signed [W-1:0] f_cur_x, f_cur_y;

  motors_dispatcher #(
    .PULSE_NUM_WIDTH(W), .POS_WIDTH(W),
    .STEP_PERIOD_CYCLES(PERIOD), .SERVO_SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset(reset),
    .pulse_num_x(pulse_num_x), .pulse_num_y(pulse_num_y),
    .servo_pos(servo_pos), .trigger(trigger),
    .new_x(new_x), .new_y(new_y), .update(update),
    .step_x(step_x), .dir_x(dir_x), .step_y(step_y), .dir_y(dir_y),
    .servo_out(servo_out), .busy(busy), .done(done),
    .cur_x(cur_x), .cur_y(cur_y)
  );

  // Compressed-period instance for the full-range count.
  motors_dispatcher #(
    .PULSE_NUM_WIDTH(W), .POS_WIDTH(W),
    .STEP_PERIOD_CYCLES(F_PERIOD), .SERVO_SETTLE_CYCLES(F_SETTLE)
  ) dut_fast (
    .clk(clk), .reset(reset),
    .pulse_num_x(f_pulse_num_x), .pulse_num_y(f_pulse_num_y),
    .servo_pos(f_servo_pos), .trigger(f_trigger),
    .new_x(f_new_x), .new_y(f_new_y), .update(f_update),
    .step_x(f_step_x), .dir_x(f_dir_x), .step_y(f_step_y), .dir_y(f_dir_y),
    .servo_out(f_servo_out), .busy(f_busy), .done(f_done),
    .cur_x(f_cur_x), .cur_y(f_cur_y)
  );

  int vectors = 0;
  int miscompares = 0;
  logic model_servo = SERVO_POS_UP;
  int model_cur_x = 0, model_cur_y = 0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({step_x, dir_x, step_y, dir_y, servo_out, busy, done} !== {4'b0000, SERVO_POS_UP, 2'b00}) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b required %b",
               {step_x, dir_x, step_y, dir_y, servo_out, busy, done}, {4'b0000, SERVO_POS_UP, 2'b00});
    end
    vectors++;
    if (cur_x !== 16'sd0 || cur_y !== 16'sd0) begin
      miscompares++;
      $display("FAIL reset_position: got %0d,%0d required 0,0", cur_x, cur_y);
    end
    reset = 1'b1;
  endtask

  // Model: settle cycles if the servo changes, then max(|x|,|y|)*PERIOD stepping cycles
  // (at least one), then the done cycle.
  task automatic run_cmd(input string name, input int x, input int y, input logic sp);
    int ax, ay, settle, exp_lat, budget, idx;
    int edges_x, edges_y, high_x, high_y, early_steps, busy_low;
    logic prev_x, prev_y;
    ax = (x < 0) ? -x : x;
    ay = (y < 0) ? -y : y;
    settle  = (sp != model_servo) ? SETTLE : 0;
    exp_lat = settle + (((ax > ay) ? ax : ay) * PERIOD > 0 ? ((ax > ay) ? ax : ay) * PERIOD : 1) + 1;
    budget  = exp_lat + 20;

    @(negedge clk);
    pulse_num_x = W'(x);
    pulse_num_y = W'(y);
    servo_pos   = sp;
    trigger     = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    model_servo = sp;
    vectors++;
    if (busy !== 1'b1 || servo_out !== sp) begin
      miscompares++;
      $display("FAIL %s accept: busy=%b servo=%b required busy=1 servo=%b", name, busy, servo_out, sp);
    end

    idx = 1; edges_x = 0; edges_y = 0; high_x = 0; high_y = 0;
    early_steps = 0; busy_low = 0; prev_x = 1'b0; prev_y = 1'b0;
    while (1) begin
      if (step_x === 1'b1) high_x++;
      if (step_y === 1'b1) high_y++;
      if (step_x === 1'b1 && prev_x !== 1'b1) edges_x++;
      if (step_y === 1'b1 && prev_y !== 1'b1) edges_y++;
      if (idx <= settle && (step_x !== 1'b0 || step_y !== 1'b0)) early_steps++;
      if (busy !== 1'b1) busy_low++;
      prev_x = step_x;
      prev_y = step_y;
      if (done === 1'b1 || idx >= budget) break;
      @(negedge clk);
      idx++;
    end

    vectors++;
    if (done !== 1'b1 || idx != exp_lat) begin
      miscompares++;
      $display("FAIL %s done_latency: got done=%b at cycle %0d required done at cycle %0d", name, done, idx, exp_lat);
    end
    vectors++;
    if (edges_x != ax || edges_y != ay) begin
      miscompares++;
      $display("FAIL %s pulse_count: got x=%0d y=%0d required x=%0d y=%0d", name, edges_x, edges_y, ax, ay);
    end
    vectors++;
    if (high_x != ax * PERIOD / 2 || high_y != ay * PERIOD / 2) begin
      miscompares++;
      $display("FAIL %s high_cycles: got x=%0d y=%0d required x=%0d y=%0d",
               name, high_x, high_y, ax * PERIOD / 2, ay * PERIOD / 2);
    end
    vectors++;
    if (early_steps != 0 || busy_low != 0) begin
      miscompares++;
      $display("FAIL %s settle_busy: got early_steps=%0d busy_low=%0d required 0,0", name, early_steps, busy_low);
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0 || dir_x !== (x < 0) || dir_y !== (y < 0) || servo_out !== sp) begin
      miscompares++;
      $display("FAIL %s after_done: got busy=%b done=%b dir=%b%b servo=%b required 0 0 %b%b %b",
               name, busy, done, dir_x, dir_y, servo_out, x < 0, y < 0, sp);
    end
  endtask

  task automatic test_same_servo();
    run_cmd("same_servo", 3, -2, SERVO_POS_UP);
  endtask

  task automatic test_servo_change();
    run_cmd("servo_change", 0, 1, SERVO_POS_DOWN);
  endtask

  task automatic test_zero_ignored();
    int bad;
    @(negedge clk);
    pulse_num_x = '0;
    pulse_num_y = '0;
    servo_pos   = model_servo;
    trigger     = 1'b1;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || step_x !== 1'b0 || step_y !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_cycle1: got busy=%b done=%b steps=%b%b required 1 0 00", busy, done, step_x, step_y);
    end
    pulse_num_x = 16'sd4;
    pulse_num_y = 16'sd4;
    servo_pos   = ~model_servo;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b1 || step_x !== 1'b0 || step_y !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_done: got busy=%b done=%b steps=%b%b required 1 1 00", busy, done, step_x, step_y);
    end
    @(negedge clk);
    trigger = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy !== 1'b0 || done !== 1'b0 || step_x !== 1'b0 || step_y !== 1'b0 || servo_out !== model_servo) bad++;
      @(negedge clk);
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL ignored_trigger: got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_position_update();
    int idx;
    @(negedge clk);
    pulse_num_x = 16'sd1;
    pulse_num_y = 16'sd0;
    servo_pos   = model_servo;
    trigger     = 1'b1;
    update      = 1'b1;
    new_x       = 16'sd7;
    new_y       = -16'sd4;
    @(negedge clk);
    trigger = 1'b0;
    update  = 1'b0;
    new_x   = 16'sd99;
    new_y   = 16'sd99;
    model_cur_x = 7;
    model_cur_y = -4;
    vectors++;
    if (cur_x !== 16'sd7 || cur_y !== -16'sd4 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL pos_update: got cur=%0d,%0d busy=%b required 7,-4 busy=1", cur_x, cur_y, busy);
    end
    idx = 1;
    while (done !== 1'b1 && idx < 30) begin
      @(negedge clk);
      idx++;
    end
    vectors++;
    if (done !== 1'b1 || idx != PERIOD + 1 || cur_x !== 16'sd7 || cur_y !== -16'sd4) begin
      miscompares++;
      $display("FAIL pos_cmd: got done=%b at %0d cur=%0d,%0d required done at %0d cur=7,-4",
               done, idx, cur_x, cur_y, PERIOD + 1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int done_seen;
    @(negedge clk);
    update = 1'b1;
    new_x  = 16'sd33;
    new_y  = -16'sd12;
    @(negedge clk);
    update = 1'b0;
    pulse_num_x = 16'sd5;
    pulse_num_y = 16'sd3;
    servo_pos   = model_servo;
    trigger     = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({step_x, dir_x, step_y, dir_y, servo_out, busy, done} !== {4'b0000, SERVO_POS_UP, 2'b00} ||
        cur_x !== 16'sd0 || cur_y !== 16'sd0) begin
      miscompares++;
      $display("FAIL reset_mid: got %b cur=%0d,%0d required %b cur=0,0",
               {step_x, dir_x, step_y, dir_y, servo_out, busy, done}, cur_x, cur_y,
               {4'b0000, SERVO_POS_UP, 2'b00});
    end
    done_seen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) done_seen++;
    end
    vectors++;
    if (done_seen != 0) begin
      miscompares++;
      $display("FAIL reset_no_done: got %0d active cycles required 0", done_seen);
    end
    model_servo = SERVO_POS_UP;
    model_cur_x = 0;
    model_cur_y = 0;
  endtask

  task automatic test_random();
    int x, y, nx, ny;
    logic sp;
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        nx = int'($urandom_range(0, 2000)) - 1000;
        ny = int'($urandom_range(0, 2000)) - 1000;
        @(negedge clk);
        update = 1'b1;
        new_x  = W'(nx);
        new_y  = W'(ny);
        @(negedge clk);
        update = 1'b0;
        model_cur_x = nx;
        model_cur_y = ny;
        vectors++;
        if (cur_x !== W'(model_cur_x) || cur_y !== W'(model_cur_y)) begin
          miscompares++;
          $display("FAIL rand_pos %0d: got %0d,%0d required %0d,%0d", n, cur_x, cur_y, model_cur_x, model_cur_y);
        end
      end
      x  = int'($urandom_range(0, 12)) - 6;
      y  = int'($urandom_range(0, 12)) - 6;
      sp = logic'($urandom_range(0, 1));
      run_cmd($sformatf("rand%0d", n), x, y, sp);
    end
  endtask

  task automatic test_extreme();
    int idx, edges_x, edges_y, exp_lat;
    logic prev_x;
    exp_lat = 32768 * F_PERIOD + 1;
    @(negedge clk);
    f_pulse_num_x = 16'sh8000;
    f_pulse_num_y = 16'sd0;
    f_servo_pos   = f_servo_out;
    f_trigger     = 1'b1;
    @(negedge clk);
    f_trigger = 1'b0;
    idx = 1; edges_x = 0; edges_y = 0; prev_x = 1'b0;
    while (1) begin
      if (f_step_x === 1'b1 && prev_x !== 1'b1) edges_x++;
      if (f_step_y === 1'b1) edges_y++;
      prev_x = f_step_x;
      if (f_done === 1'b1 || idx >= exp_lat + 20) break;
      @(negedge clk);
      idx++;
    end
    vectors++;
    if (f_done !== 1'b1 || idx != exp_lat) begin
      miscompares++;
      $display("FAIL extreme_latency: got done=%b at %0d required done at %0d", f_done, idx, exp_lat);
    end
    vectors++;
    if (edges_x != 32768 || edges_y != 0 || f_dir_x !== 1'b1 || f_dir_y !== 1'b0) begin
      miscompares++;
      $display("FAIL extreme_pulses: got x=%0d y=%0d dir=%b%b required x=32768 y=0 dir=10",
               edges_x, edges_y, f_dir_x, f_dir_y);
    end
  endtask

  initial begin
    test_reset();
    test_same_servo();
    test_servo_change();
    test_zero_ignored();
    test_position_update();
    test_reset_mid();
    test_random();
    test_extreme();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
